usb_in_ep_buffer: RTL

//  Double-buffered (ping-pong) USB full-speed IN endpoint. Endpoint clients (e.g. control/CDC

---
 rtl/usb_pkg.sv | 19 +
 rtl/usb_ep_ram.sv | 24 ++
 rtl/usb_in_ep_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB endpoint types: per-buffer state and data PID constants.
package usb_pkg;

    // Lifecycle of one packet buffer in the ping-pong pair.
    typedef enum logic [1:0] {
        BufFilling = 2'd0,
        BufReady   = 2'd1,
        BufSending = 2'd2
    } buf_state_e;

    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;

    // PID the engine should send for a given data toggle.
    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? PidData1 : PidData0;
    endfunction

endpackage

// File: rtl/usb_ep_ram.sv
// Packet RAM for both endpoint buffers: one synchronous write port, one
// asynchronous read port. Address MSB selects the buffer.
module usb_ep_ram #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [2**AW];

    // Byte write from the fill side.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_in_ep_buffer.sv
// Double-buffered USB full-speed IN endpoint. The client fills one buffer
// while the protocol engine drains the other; owns DATA0/1 toggle, STALL
// and retransmission when the host does not ACK.
module usb_in_ep_buffer
    import usb_pkg::*;
#(
    parameter int unsigned MAX_PKT = 32,
    parameter int unsigned PW      = $clog2(MAX_PKT) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       setup_token,
    input  logic       in_token,
    output logic       tx_pkt_ready,
    output logic       tx_stall,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    output logic       tx_data_toggle,
    input  logic       tx_acked
);
    localparam logic [PW-1:0] MaxLen = PW'(MAX_PKT);

    buf_state_e    state_q [2];
    buf_state_e    state_d [2];
    logic [PW-1:0] len_q [2];
    logic [PW-1:0] len_d [2];
    logic          fill_sel_q, fill_sel_d;
    logic          send_sel_q, send_sel_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          toggle_q, toggle_d;
    logic          stall_q, stall_d;
    logic          acked_q, acked_d;
    logic          grant_q;

    logic          fill_filling, put_ok, fill_close;
    logic          send_active, get_ok, ack_ok, flush;
    logic [PW-1:0] fill_cur_len, fill_len, send_len;
    logic [7:0]    ram_rdata;

    assign fill_cur_len    = len_q[fill_sel_q];
    assign send_len        = len_q[send_sel_q];
    assign fill_filling    = (state_q[fill_sel_q] == BufFilling);
    assign in_ep_data_free = fill_filling && (fill_cur_len < MaxLen);
    assign put_ok          = in_ep_data_put && in_ep_data_free;
    assign fill_len        = fill_cur_len + PW'(put_ok);
    // Close on explicit done, or when the byte landing now fills the buffer.
    assign fill_close      = fill_filling && (in_ep_data_done || (put_ok && fill_len == MaxLen));

    assign send_active   = (state_q[send_sel_q] == BufReady) ||
                           (state_q[send_sel_q] == BufSending);
    assign tx_pkt_ready  = !stall_q && send_active;
    assign tx_data_avail = tx_pkt_ready && (rd_ptr_q < send_len);
    assign get_ok        = tx_data_avail && tx_data_get;
    assign ack_ok        = !stall_q && tx_acked && (state_q[send_sel_q] == BufSending);
    assign flush         = stall_q || in_ep_stall || setup_token;

    assign tx_data        = tx_data_avail ? ram_rdata : 8'h00;
    assign tx_stall       = stall_q;
    assign tx_data_toggle = toggle_q;
    assign in_ep_acked    = acked_q;
    assign in_ep_grant    = grant_q;

    usb_ep_ram #(
        .AW(PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (put_ok),
        .waddr_i ({fill_sel_q, fill_cur_len[PW-2:0]}),
        .wdata_i (in_ep_data),
        .raddr_i ({send_sel_q, rd_ptr_q[PW-2:0]}),
        .rdata_o (ram_rdata)
    );

    // Next-state for buffers, pointers, toggle and stall.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        fill_sel_d = fill_sel_q;
        send_sel_d = send_sel_q;
        rd_ptr_d   = rd_ptr_q;
        toggle_d   = toggle_q;
        stall_d    = stall_q;
        acked_d    = 1'b0;

        if (fill_close) begin
            state_d[fill_sel_q] = BufReady;
            len_d[fill_sel_q]   = fill_len;
            fill_sel_d          = ~fill_sel_q;
        end else if (put_ok) begin
            len_d[fill_sel_q] = fill_len;
        end

        if (get_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A token while already SENDING means the host missed our data: rewind.
        if (in_token && tx_pkt_ready) begin
            state_d[send_sel_q] = BufSending;
            rd_ptr_d            = '0;
        end

        // ACK always targets the SENDING buffer, never the one being filled.
        if (ack_ok) begin
            state_d[send_sel_q] = BufFilling;
            len_d[send_sel_q]   = '0;
            send_sel_d          = ~send_sel_q;
            rd_ptr_d            = '0;
            toggle_d            = ~toggle_q;
            acked_d             = 1'b1;
        end

        if (flush) begin
            state_d[0] = BufFilling;
            state_d[1] = BufFilling;
            len_d[0]   = '0;
            len_d[1]   = '0;
            fill_sel_d = 1'b0;
            send_sel_d = 1'b0;
            rd_ptr_d   = '0;
        end

        // Data stage after SETUP always starts with DATA1.
        if (setup_token) begin
            stall_d  = 1'b0;
            toggle_d = 1'b1;
        end
        if (in_ep_stall) begin
            stall_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0] <= BufFilling;
            state_q[1] <= BufFilling;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            fill_sel_q <= 1'b0;
            send_sel_q <= 1'b0;
            rd_ptr_q   <= '0;
            toggle_q   <= 1'b0;
            stall_q    <= 1'b0;
            acked_q    <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            fill_sel_q <= fill_sel_d;
            send_sel_q <= send_sel_d;
            rd_ptr_q   <= rd_ptr_d;
            toggle_q   <= toggle_d;
            stall_q    <= stall_d;
            acked_q    <= acked_d;
            grant_q    <= in_ep_req;
        end
    end

endmodule
